// File: rtl/wb_trace_serializer.sv
// Dual-slot writeback trace serializer.
// Up to two retired writeback records per cycle are pushed, oldest first,
// into a small FIFO and presented one record at a time on a valid/ready
// stream. Each record carries a 16-bit sequence number, so records dropped
// on overflow show up as gaps in out_seq. The block also flags when either
// slot reaches the end-of-test PC and when the buffer has drained after that.
module wb_trace_serializer #(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] END_PC = 32'hBFC00100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s0_pc,
  input  logic [3:0]  s0_wen,
  input  logic [4:0]  s0_wnum,
  input  logic [31:0] s0_wdata,
  input  logic [31:0] s1_pc,
  input  logic [3:0]  s1_wen,
  input  logic [4:0]  s1_wnum,
  input  logic [31:0] s1_wdata,
  input  logic        s1_first,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  out_wen,
  output logic [4:0]  out_wnum,
  output logic [31:0] out_wdata,
  output logic [15:0] out_seq,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic        end_hit,
  output logic        drained
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic [15:0] seq;
  } rec_t;

  rec_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [15:0]   seq_cnt;

  logic          v0;
  logic          v1;
  logic          older_s1;
  logic [1:0]    n_valid;
  logic [1:0]    n_push;
  logic [1:0]    n_drop;
  logic          pop;
  logic          accept;
  logic [AW+1:0] free;
  logic [AW-1:0] wr_ptr_n1;
  logic [16:0]   drop_sum;
  rec_t          rec0;
  rec_t          rec1;
  rec_t          rec_a;
  rec_t          rec_b;
  rec_t          head;

  // Classify the slots, order them by age and decide whether this cycle's
  // records fit (all or nothing), counting a same-cycle pop as free space.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value held over and no latch is inferred.
  always_comb begin
    v0        = |s0_wen;
    v1        = |s1_wen;
    n_valid   = {1'b0, v0} + {1'b0, v1};
    older_s1  = v1 && (!v0 || s1_first);
    pop       = out_valid && out_ready;
    free      = (AW+2)'(DEPTH) - {1'b0, count} + (AW+2)'(pop);
    accept    = (AW+2)'(n_valid) <= free;
    n_push    = accept ? n_valid : 2'd0;
    n_drop    = accept ? 2'd0 : n_valid;
    wr_ptr_n1 = wr_ptr + AW'(1);
    drop_sum  = {1'b0, drop_cnt} + 17'(n_drop);

    rec0      = '{pc: s0_pc, wen: s0_wen, wnum: s0_wnum, wdata: s0_wdata, seq: 16'h0};
    rec1      = '{pc: s1_pc, wen: s1_wen, wnum: s1_wnum, wdata: s1_wdata, seq: 16'h0};
    rec_a     = older_s1 ? rec1 : rec0;
    rec_b     = older_s1 ? rec0 : rec1;
    rec_a.seq = seq_cnt;
    rec_b.seq = seq_cnt + 16'd1;
  end

  // Record storage: written at the write pointer, the older record first.
  // NOTE: the storage array has no reset; count and the pointers define which
  // entries are live, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (n_push != 2'd0) mem[wr_ptr]    <= rec_a;
      if (n_push == 2'd2) mem[wr_ptr_n1] <= rec_b;
    end
  end

  // Pointers, occupancy, sequence numbering and sticky status flags.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      seq_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      end_hit  <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(n_push);
      rd_ptr  <= rd_ptr + AW'(pop);
      count   <= count + (AW+1)'(n_push) - (AW+1)'(pop);
      // Dropped records still consume sequence numbers so gaps are visible.
      seq_cnt <= seq_cnt + 16'(n_valid);
      if (n_drop != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      if (s0_pc == END_PC || s1_pc == END_PC) end_hit <= 1'b1;
    end
  end

  // Present the FIFO head; fields read as zero while the buffer is empty.
  always_comb begin
    head      = mem[rd_ptr];
    out_valid = (count != '0);
    out_pc    = out_valid ? head.pc    : '0;
    out_wen   = out_valid ? head.wen   : '0;
    out_wnum  = out_valid ? head.wnum  : '0;
    out_wdata = out_valid ? head.wdata : '0;
    out_seq   = out_valid ? head.seq   : '0;
    drained   = end_hit && (count == '0);
  end

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Self-checking bench for wb_trace_serializer: a directed vector table,
// hand-written multi-cycle sequences and a randomized run, all checked
// against a queue-based reference model of the trace stream.
module tb_wb_trace_serializer;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] END_PC = 32'hBFC00100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s0_pc, s1_pc, s0_wdata, s1_wdata;
  logic [3:0]  s0_wen, s1_wen;
  logic [4:0]  s0_wnum, s1_wnum;
  logic        s1_first;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_wdata;
  logic [3:0]  out_wen;
  logic [4:0]  out_wnum;
  logic [15:0] out_seq, drop_cnt;
  logic        overflow, end_hit, drained;

  wb_trace_serializer #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk(clk), .rst(rst),
    .s0_pc(s0_pc), .s0_wen(s0_wen), .s0_wnum(s0_wnum), .s0_wdata(s0_wdata),
    .s1_pc(s1_pc), .s1_wen(s1_wen), .s1_wnum(s1_wnum), .s1_wdata(s1_wdata),
    .s1_first(s1_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_wen(out_wen), .out_wnum(out_wnum), .out_wdata(out_wdata),
    .out_seq(out_seq), .overflow(overflow), .drop_cnt(drop_cnt),
    .end_hit(end_hit), .drained(drained)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream is a queue of records.
  typedef struct {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    int          seq;
  } mrec_t;

  mrec_t mq[$];
  int    m_seq  = 0;
  int    m_drop = 0;
  bit    m_ovf  = 0;
  bit    m_end  = 0;

  task automatic model_step();
    mrec_t arr[2];
    int    nv;
    int    free_sp;
    bit    do_pop;
    if (rst) begin
      mq.delete();
      m_seq = 0; m_drop = 0; m_ovf = 0; m_end = 0;
      return;
    end
    nv = 0;
    if (s1_first && s1_wen != 0) begin
      arr[nv] = '{s1_pc, s1_wen, s1_wnum, s1_wdata, 0}; nv++;
    end
    if (s0_wen != 0) begin
      arr[nv] = '{s0_pc, s0_wen, s0_wnum, s0_wdata, 0}; nv++;
    end
    if (!s1_first && s1_wen != 0) begin
      arr[nv] = '{s1_pc, s1_wen, s1_wnum, s1_wdata, 0}; nv++;
    end
    do_pop  = (mq.size() != 0) && out_ready;
    free_sp = DEPTH - mq.size() + int'(do_pop);
    if (do_pop) void'(mq.pop_front());
    if (nv <= free_sp) begin
      for (int i = 0; i < nv; i++) begin
        arr[i].seq = m_seq & 16'hFFFF;
        m_seq++;
        mq.push_back(arr[i]);
      end
    end else begin
      m_ovf  = 1;
      m_drop = (m_drop + nv > 65535) ? 65535 : m_drop + nv;
      m_seq += nv;
    end
    if (s0_pc == END_PC || s1_pc == END_PC) m_end = 1;
  endtask

  task automatic model_check();
    check("m_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("m_pc",    out_pc,    mq[0].pc);
      check("m_wen",   out_wen,   mq[0].wen);
      check("m_wnum",  out_wnum,  mq[0].wnum);
      check("m_wdata", out_wdata, mq[0].wdata);
      check("m_seq",   out_seq,   64'(mq[0].seq));
    end
    check("m_overflow", overflow, m_ovf);
    check("m_drop_cnt", drop_cnt, 64'(m_drop));
    check("m_end_hit",  end_hit,  m_end);
    check("m_drained",  drained,  m_end && mq.size() == 0);
  endtask

  // One clock: inputs were set after the previous falling edge; the model
  // sees the same inputs at the rising edge and outputs are compared 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
    @(negedge clk);
  endtask

  task automatic set_idle();
    s0_pc = 0; s1_pc = 0; s0_wen = 0; s1_wen = 0; s1_first = 0;
    s0_wnum = 0; s1_wnum = 0; s0_wdata = 0; s1_wdata = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1; out_ready = 0;
    tick();
    rst = 0;
  endtask

  task automatic dual(input logic [31:0] p0, input logic [31:0] p1, input logic first);
    s0_pc = p0; s0_wen = 4'hF; s0_wnum = 5'd1; s0_wdata = p0 ^ 32'h5A5A;
    s1_pc = p1; s1_wen = 4'h3; s1_wnum = 5'd2; s1_wdata = p1 ^ 32'hA5A5;
    s1_first = first;
  endtask

  // Fill with four dual-issue cycles while the sink stalls: pcs 0x1000..0x101C.
  task automatic fill8();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      dual(32'h1000 + 32'(i * 8), 32'h1004 + 32'(i * 8), 1'b0);
      tick();
      check("fill_head_stable", out_pc, 32'h1000);
    end
    set_idle();
  endtask

  // Pop until empty (bounded); returns number of records popped.
  task automatic drain(output int pops);
    pops = 0;
    set_idle();
    out_ready = 1;
    for (int i = 0; i < 4 * DEPTH && out_valid; i++) begin
      pops++;
      tick();
    end
    check("drain_empty", out_valid, 1'b0);
  endtask

  typedef struct {
    logic [31:0] s0_pc;
    logic [3:0]  s0_wen;
    logic [31:0] s1_pc;
    logic [3:0]  s1_wen;
    logic        s1_first;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [15:0] e_seq;
  } vec_t;

  vec_t tbl[10];
  int   pops;

  initial begin
    tbl[0] = '{32'hBFC00000, 4'hF, 32'h0,   4'h0, 1'b0, 1'b1, 1'b1, 32'hBFC00000, 16'd0};
    tbl[1] = '{32'h0,        4'h0, 32'h0,   4'h0, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0};
    tbl[2] = '{32'h104,      4'hF, 32'h100, 4'hF, 1'b1, 1'b0, 1'b1, 32'h100,      16'd1};
    tbl[3] = '{32'h0,        4'h0, 32'h0,   4'h0, 1'b0, 1'b1, 1'b1, 32'h104,      16'd2};
    tbl[4] = '{32'h0,        4'h0, 32'h0,   4'h0, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0};
    tbl[5] = '{32'h204,      4'h1, 32'h200, 4'h8, 1'b0, 1'b1, 1'b1, 32'h204,      16'd3};
    tbl[6] = '{32'h0,        4'h0, 32'h0,   4'h0, 1'b0, 1'b1, 1'b1, 32'h200,      16'd4};
    tbl[7] = '{32'h0,        4'h0, 32'h0,   4'h0, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0};
    tbl[8] = '{32'h0,        4'h0, 32'h300, 4'h6, 1'b0, 1'b1, 1'b1, 32'h300,      16'd5};
    tbl[9] = '{32'h0,        4'h0, 32'h0,   4'h0, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0};

    set_idle();
    rst = 1; out_ready = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    check("rst_valid",    out_valid, 1'b0);
    check("rst_seq",      out_seq,   16'd0);
    check("rst_overflow", overflow,  1'b0);
    check("rst_drop_cnt", drop_cnt,  16'd0);
    check("rst_end_hit",  end_hit,   1'b0);
    check("rst_drained",  drained,   1'b0);

    // Directed vectors: single issue and both dual-issue orderings.
    for (int i = 0; i < 10; i++) begin
      set_idle();
      s0_pc = tbl[i].s0_pc; s0_wen = tbl[i].s0_wen; s0_wnum = 5'd5; s0_wdata = 32'h1234;
      s1_pc = tbl[i].s1_pc; s1_wen = tbl[i].s1_wen; s1_wnum = 5'd7; s1_wdata = 32'h5678;
      s1_first = tbl[i].s1_first; out_ready = tbl[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), out_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d_pc", i),  out_pc,  tbl[i].e_pc);
        check($sformatf("vec%0d_seq", i), out_seq, tbl[i].e_seq);
      end
    end

    // Full buffer with a same-cycle pop: the single push is accepted.
    do_reset();
    fill8();
    out_ready = 1;
    s0_pc = 32'h2000; s0_wen = 4'hF; s0_wnum = 5'd3; s0_wdata = 32'h77;
    tick();
    check("fullpop_overflow", overflow, 1'b0);
    check("fullpop_head",     out_pc,   32'h1004);
    drain(pops);
    check("fullpop_count", 64'(pops), 64'd8);

    // Full buffer, stalled sink: fifth dual cycle dropped, seq skips two.
    do_reset();
    fill8();
    dual(32'h1100, 32'h1104, 1'b1);
    tick();
    check("drop_overflow", overflow, 1'b1);
    check("drop_cnt",      drop_cnt, 16'd2);
    check("drop_head_pc",  out_pc,   32'h1000);
    check("drop_head_seq", out_seq,  16'd0);
    drain(pops);
    check("drop_drain_count", 64'(pops), 64'd8);
    out_ready = 0;
    s0_pc = 32'h3000; s0_wen = 4'h1;
    tick();
    check("drop_seq_gap", out_seq, 16'd10);

    // End detect with three records buffered.
    do_reset();
    dual(32'h500, 32'h504, 1'b0);
    tick();
    set_idle();
    s1_pc = 32'h508; s1_wen = 4'hC;
    tick();
    set_idle();
    s0_pc = END_PC;
    tick();
    check("end_hit",       end_hit, 1'b1);
    check("end_drained0",  drained, 1'b0);
    set_idle();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("end_wait%0d", i), drained, 1'b0);
      tick();
    end
    check("end_drained1", drained, 1'b1);

    // Reset mid-stream with five records buffered and drops recorded.
    do_reset();
    fill8();
    dual(32'h1100, 32'h1104, 1'b0);
    tick();
    set_idle();
    out_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    check("mid_drop_pre", drop_cnt, 16'd2);
    rst = 1;
    tick();
    rst = 0;
    check("mid_valid",    out_valid, 1'b0);
    check("mid_seq",      out_seq,   16'd0);
    check("mid_drop_cnt", drop_cnt,  16'd0);
    check("mid_overflow", overflow,  1'b0);
    tick();
    check("mid_after_valid", out_valid, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s0_wen   = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
      s1_wen   = ($urandom_range(0, 9) < 5) ? 4'h0 : 4'($urandom_range(1, 15));
      s0_pc    = ($urandom_range(0, 499) == 0) ? END_PC : $urandom();
      s1_pc    = $urandom();
      s0_wnum  = 5'($urandom());
      s1_wnum  = 5'($urandom());
      s0_wdata = $urandom();
      s1_wdata = $urandom();
      s1_first = 1'($urandom());
      out_ready = ($urandom_range(0, 9) < 5);
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
